// File: rtl/ycbcr_to_rgb_conversion.sv
// Three-stage fixed-point YCbCr -> RGB converter (offset, multiply, sum/round/clamp) with a global-stall handshake.
// Define YCBCR2RGB_CLAMP_EN to saturate each channel to 0..255; otherwise channels wrap modulo 256.
module ycbcr_to_rgb_conversion #(
   parameter int SCALE              = 16,
   parameter int FIXED_POINT_LENGTH = 32,
   parameter int OUTPUT_WIDTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [FIXED_POINT_LENGTH-1:0] input_Y,
   input  logic [FIXED_POINT_LENGTH-1:0] input_Cb,
   input  logic [FIXED_POINT_LENGTH-1:0] input_Cr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUTPUT_WIDTH-1:0]       output_R,
   output logic [OUTPUT_WIDTH-1:0]       output_G,
   output logic [OUTPUT_WIDTH-1:0]       output_B
);

   localparam int FPL = FIXED_POINT_LENGTH;
   localparam int OFW = FPL + 1;
   localparam int PW  = FPL + 24;

   localparam logic signed [OFW-1:0] OFFSET_128 = OFW'(64'd128 << SCALE);
   localparam logic signed [PW-1:0]  K_RCR      = PW'(91881);
   localparam logic signed [PW-1:0]  K_GCB      = PW'(22554);
   localparam logic signed [PW-1:0]  K_GCR      = PW'(46802);
   localparam logic signed [PW-1:0]  K_BCB      = PW'(116130);
   localparam logic signed [PW-1:0]  ROUND_HALF = PW'(64'd1 << (SCALE + 15));
   localparam logic signed [PW-1:0]  CH_MAX     = PW'((64'd1 << OUTPUT_WIDTH) - 64'd1);

   logic adv;

   logic v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
   logic        [FPL-1:0] y1_q, y1_d;
   logic signed [OFW-1:0] cb_off_q, cb_off_d, cr_off_q, cr_off_d;
   logic signed [PW-1:0]  y2_q, y2_d;
   logic signed [PW-1:0]  p_rcr_q, p_rcr_d, p_gcb_q, p_gcb_d;
   logic signed [PW-1:0]  p_gcr_q, p_gcr_d, p_bcb_q, p_bcb_d;
   logic [OUTPUT_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   // Sum at scale 2^(SCALE+16) -> round half up -> 8-bit channel.
   function automatic logic [OUTPUT_WIDTH-1:0] to_pixel(input logic signed [PW-1:0] sum);
      logic signed [PW-1:0] v;
      v = (sum + ROUND_HALF) >>> (SCALE + 16);
`ifdef YCBCR2RGB_CLAMP_EN
      if (v[PW-1])
         return '0;
      else if (v > CH_MAX)
         return '1;
      else
         return v[OUTPUT_WIDTH-1:0];
`else
      return v[OUTPUT_WIDTH-1:0];
`endif
   endfunction

   assign adv = !out_valid_q || out_ready;

   always_comb begin
      v1_d        = v1_q;
      y1_d        = y1_q;
      cb_off_d    = cb_off_q;
      cr_off_d    = cr_off_q;
      v2_d        = v2_q;
      y2_d        = y2_q;
      p_rcr_d     = p_rcr_q;
      p_gcb_d     = p_gcb_q;
      p_gcr_d     = p_gcr_q;
      p_bcb_d     = p_bcb_q;
      out_valid_d = out_valid_q;
      r_d         = r_q;
      g_d         = g_q;
      b_d         = b_q;
      if (adv) begin
         v1_d = in_valid;
         if (in_valid) begin
            y1_d     = input_Y;
            cb_off_d = $signed({1'b0, input_Cb}) - OFFSET_128;
            cr_off_d = $signed({1'b0, input_Cr}) - OFFSET_128;
         end
         v2_d = v1_q;
         if (v1_q) begin
            y2_d    = $signed(PW'({y1_q, 16'h0000}));
            p_rcr_d = PW'(cr_off_q) * K_RCR;
            p_gcb_d = PW'(cb_off_q) * K_GCB;
            p_gcr_d = PW'(cr_off_q) * K_GCR;
            p_bcb_d = PW'(cb_off_q) * K_BCB;
         end
         // Output data only moves with a real pixel so bubbles leave the last pixel visible.
         out_valid_d = v2_q;
         if (v2_q) begin
            r_d = to_pixel(y2_q + p_rcr_q);
            g_d = to_pixel(y2_q - p_gcb_q - p_gcr_q);
            b_d = to_pixel(y2_q + p_bcb_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         y1_q        <= '0;
         cb_off_q    <= '0;
         cr_off_q    <= '0;
         v2_q        <= 1'b0;
         y2_q        <= '0;
         p_rcr_q     <= '0;
         p_gcb_q     <= '0;
         p_gcr_q     <= '0;
         p_bcb_q     <= '0;
         out_valid_q <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
      end else begin
         v1_q        <= v1_d;
         y1_q        <= y1_d;
         cb_off_q    <= cb_off_d;
         cr_off_q    <= cr_off_d;
         v2_q        <= v2_d;
         y2_q        <= y2_d;
         p_rcr_q     <= p_rcr_d;
         p_gcb_q     <= p_gcb_d;
         p_gcr_q     <= p_gcr_d;
         p_bcb_q     <= p_bcb_d;
         out_valid_q <= out_valid_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign output_R  = r_q;
   assign output_G  = g_q;
   assign output_B  = b_q;

endmodule
